// File: rtl/cpu_status_unit_pkg.sv
// -----------------------------------------------------------------------------
// cpu_status_unit_pkg
// Shared CPU definitions for the pipeline status/control unit.
//   run_state_t   : run-control FSM state encoding (RUN/DRAIN/HALTED/FAULT)
//   ERR_*         : err_code encodings, bit 0 = opcode error, bit 1 = funct error
//   is_counting() : true in the states where the cycle counter advances
// -----------------------------------------------------------------------------
package cpu_status_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAULT  = 2'd3
  } run_state_t;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_OPCODE = 2'd1;
  localparam logic [1:0] ERR_FUNCT  = 2'd2;
  localparam logic [1:0] ERR_BOTH   = 2'd3;

  // Cycles are billed while the core is doing useful work: running or
  // draining in-flight instructions after a HALT.
  function automatic logic is_counting(input run_state_t s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that increments by one when enabled and sticks at all-ones.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-high reset, clears the count
//   en     : increment request for this cycle
//   count  : registered count value, W bits
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking (=) here creates simulation/synthesis races.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != MAX)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/cpu_status_unit.sv
// -----------------------------------------------------------------------------
// cpu_status_unit
// Run-control FSM for a pipelined CPU: stops the PC on HALT or decode faults,
// flushes IF/ID once on entry to DRAIN/FAULT, captures fault information and
// keeps saturating cycle/retired-instruction counters.
// Ports:
//   clock, reset      : clock and asynchronous active-high reset
//   wb_retire         : an instruction retires in WB this cycle
//   id_halt           : HALT opcode decoded in ID
//   id_opcode_err     : unknown opcode in ID
//   id_funct_err      : unknown function code in ID
//   id_pc             : PC of the instruction in ID
//   pipe_empty        : EX/M/WB hold no valid instruction
//   pc_stop           : freeze PC (registered)
//   if_id_flush       : one-cycle IF/ID flush (registered)
//   run_state         : FSM state encoding
//   cycle_count       : cycles spent in RUN or DRAIN (saturating)
//   retired_count     : retired instructions (saturating)
//   err_code          : {funct_err, opcode_err} latched at the fault
//   err_pc            : id_pc latched at the fault
// -----------------------------------------------------------------------------
module cpu_status_unit
  import cpu_status_unit_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PC_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wb_retire,
  input  logic             id_halt,
  input  logic             id_opcode_err,
  input  logic             id_funct_err,
  input  logic [PC_W-1:0]  id_pc,
  input  logic             pipe_empty,
  output logic             pc_stop,
  output logic             if_id_flush,
  output logic [1:0]       run_state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count,
  output logic [1:0]       err_code,
  output logic [PC_W-1:0]  err_pc
);

  run_state_t state;

  // All outputs come straight from flops; pc_stop and if_id_flush are set on
  // the same edge that leaves RUN so they line up with the new state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      pc_stop     <= 1'b0;
      if_id_flush <= 1'b0;
      err_code    <= ERR_NONE;
      err_pc      <= '0;
    end else begin
      if_id_flush <= 1'b0;
      unique case (state)
        ST_RUN: begin
          // Decode faults win over HALT in the same cycle.
          if (id_opcode_err || id_funct_err) begin
            state       <= ST_FAULT;
            pc_stop     <= 1'b1;
            if_id_flush <= 1'b1;
            err_code    <= {id_funct_err, id_opcode_err};
            err_pc      <= id_pc;
          end else if (id_halt) begin
            state       <= ST_DRAIN;
            pc_stop     <= 1'b1;
            if_id_flush <= 1'b1;
          end
        end
        ST_DRAIN: begin
          // Evaluated only once we are in DRAIN, so an already-empty pipe
          // still spends one cycle here before HALTED.
          if (pipe_empty) begin
            state <= ST_HALTED;
          end
        end
        default: begin
          // HALTED and FAULT are terminal until reset.
        end
      endcase
    end
  end

  assign run_state = state;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clock (clock),
    .reset (reset),
    .en    (is_counting(state)),
    .count (cycle_count)
  );

  // Retirements are counted in every state so the tail of a DRAIN is included.
  sat_counter #(.W(CNT_W)) u_retired_cnt (
    .clock (clock),
    .reset (reset),
    .en    (wb_retire),
    .count (retired_count)
  );

endmodule

// File: doc/cpu_status_unit.md
CPU_STATUS_UNIT -- requirements
Module: cpu_status_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the cycle and retired counters.
REQ-002 SHALL have parameter PC_W, default 16, width of the PC captured on a fault.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port wb_retire, input, 1, one instruction completes writeback this cycle.
REQ-006 SHALL have port id_halt, input, 1, decode has recognised a HALT opcode.
REQ-007 SHALL have port id_opcode_err, input, 1, decode has seen an unknown opcode.
REQ-008 SHALL have port id_funct_err, input, 1, decode has seen an unknown function code.
REQ-009 SHALL have port id_pc, input, PC_W, PC of the instruction currently in ID.
REQ-010 SHALL have port pipe_empty, input, 1, no valid instruction in EX/M/WB.
REQ-011 SHALL have port pc_stop, output, 1, freezes the PC register.
REQ-012 SHALL have port if_id_flush, output, 1, single-cycle flush of the IF/ID buffer.
REQ-013 SHALL have port run_state, output, 2, current FSM state encoding.
REQ-014 SHALL have port cycle_count, output, CNT_W, cycles spent in RUN or DRAIN.
REQ-015 SHALL have port retired_count, output, CNT_W, instructions retired.
REQ-016 SHALL have port err_code, output, 2, 0 none, 1 opcode, 2 funct, 3 both.
REQ-017 SHALL have port err_pc, output, PC_W, id_pc captured at the fault.

Function
REQ-018 SHALL implement states RUN=0, DRAIN=1, HALTED=2, FAULT=3.
REQ-019 SHALL, in RUN, move to FAULT when id_opcode_err or id_funct_err is high, with priority over id_halt.
REQ-020 SHALL, in RUN with no error and id_halt high, move to DRAIN.
REQ-021 SHALL, in DRAIN, move to HALTED on the first cycle pipe_empty is high; if pipe_empty is already high on DRAIN entry, HALTED follows one cycle later.
REQ-022 SHALL treat HALTED and FAULT as terminal; only reset leaves them.
REQ-023 SHALL ignore id_halt and error inputs while in DRAIN, HALTED, or FAULT.
REQ-024 SHALL drive pc_stop high, registered, in DRAIN, HALTED, and FAULT, and low in RUN.
REQ-025 SHALL pulse if_id_flush high for exactly the first cycle after entering DRAIN or FAULT.
REQ-026 SHALL increment cycle_count by 1 each cycle in RUN or DRAIN, and hold it in HALTED and FAULT.
REQ-027 SHALL increment retired_count by 1 on each cycle wb_retire is high in any state, so DRAIN retirements are counted.
REQ-028 SHALL saturate both counters at all-ones with no wrap.
REQ-029 SHALL, on the RUN->FAULT transition, latch err_code as {id_funct_err, id_opcode_err} and latch err_pc as id_pc; both then hold until reset.
REQ-030 SHALL have all outputs registered and no combinational input-to-output path.

Reset
REQ-031 SHALL, on reset assertion and independent of clock, set run_state=RUN, pc_stop=0, if_id_flush=0, both counters=0, err_code=0, err_pc=0.
REQ-032 SHALL, when reset is asserted mid-DRAIN or mid-fault, abandon the state and return to RUN with counters cleared.
REQ-033 SHALL not count the first rising edge after reset release as a cycle unless reset is already low at that edge.

Structure
REQ-034 SHALL place the state encodings and err_code encodings in the shared CPU definitions package.
REQ-035 SHALL use one sub-module, sat_counter (parameterised width, enable, synchronous hold at max), instantiated twice.

Verification
REQ-036 SHALL cover: reset, then 10 cycles in RUN with wb_retire high on 6 of them -> cycle_count=10, retired_count=6, pc_stop=0.
REQ-037 SHALL cover: id_halt at cycle 5 with pipe_empty low for 3 cycles -> DRAIN, one if_id_flush pulse, pc_stop=1, HALTED after pipe_empty rises, cycle_count frozen.
REQ-038 SHALL cover: id_opcode_err and id_funct_err together with id_halt, id_pc=0x0042 -> FAULT, err_code=3, err_pc=0x0042.
REQ-039 SHALL cover: CNT_W=4 and 20 RUN cycles -> cycle_count=0xF and held.
REQ-040 SHALL cover: reset asserted between clock edges while in DRAIN -> outputs immediately take the REQ-031 values, and RUN resumes after release.
